// File: rtl/dr_alm_pipelined_mult.sv
// dr_alm_pipelined_mult: three-stage dynamic-range approximate log multiplier
// (LOD/log -> log add -> antilog) with a valid/ready handshake and a sideband tag.
// Optional feature: define DR_ALM_SIGNED_EN for two's-complement operands.
module dr_alm_pipelined_mult #(
    parameter int unsigned A_BW    = 16,
    parameter int unsigned B_BW    = 16,
    parameter int unsigned MULT_DW = 5,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_BW-1:0]      a,
    input  logic [B_BW-1:0]      b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_BW+B_BW-1:0] p,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned MAX_BW = (A_BW > B_BW) ? A_BW : B_BW;
    localparam int unsigned LG     = $clog2(MAX_BW);
    localparam int unsigned F      = MULT_DW + 1;
    localparam int unsigned L_W    = LG + F;
    localparam int unsigned S_W    = L_W + 1;
    localparam int unsigned P_W    = A_BW + B_BW;
    // Antilog intermediate: (2^F + m) << K never exceeds F + 2*MAX_BW bits.
    localparam int unsigned EXT_W  = F + 2 * MAX_BW;

    // Log word {k, f, 1}: leading-one index, MULT_DW bits below it, unbiasing bit.
    function automatic logic [L_W-1:0] log_word(input logic [MAX_BW-1:0] x);
        logic [LG-1:0]      k;
        logic [MAX_BW-1:0]  norm;
        logic [MULT_DW-1:0] f;
        k = '0;
        for (int i = 0; i < MAX_BW; i++) begin
            if (x[i]) k = LG'(i);
        end
        norm = x << (LG'(MAX_BW - 1) - k);
        f    = MULT_DW'(norm >> (MAX_BW - 1 - MULT_DW));
        return {k, f, 1'b1};
    endfunction

    logic             advance;
    logic             v1_q, v2_q, v3_q;
    logic [L_W-1:0]   la_d, lb_d, la_q, lb_q;
    logic             z1_d, z1_q, z2_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic [S_W-1:0]   s_d, s_q;
    logic [EXT_W-1:0] ext;
    logic [P_W-1:0]   p_d, p_q;
    logic [A_BW-1:0]  mag_a;
    logic [B_BW-1:0]  mag_b;
`ifdef DR_ALM_SIGNED_EN
    logic             sg1_d, sg1_q, sg2_q;
`endif

    // Whole pipeline moves together whenever the output slot is free or draining.
    assign advance   = !v3_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = v3_q;
    assign p         = p_q;
    assign out_tag   = tag3_q;

    // Stage 1 combinational: operand magnitudes, zero detect, log conversion.
    always_comb begin
`ifdef DR_ALM_SIGNED_EN
        mag_a = a[A_BW-1] ? A_BW'(-a) : a;
        mag_b = b[B_BW-1] ? B_BW'(-b) : b;
        sg1_d = a[A_BW-1] ^ b[B_BW-1];
`else
        mag_a = a;
        mag_b = b;
`endif
        z1_d = (mag_a == '0) || (mag_b == '0);
        la_d = log_word(MAX_BW'(mag_a));
        lb_d = log_word(MAX_BW'(mag_b));
    end

    // Stage 2 combinational: log-domain add.
    assign s_d = S_W'(la_q) + S_W'(lb_q);

    // Stage 3 combinational: antilog, zero force and optional negate.
    always_comb begin
        ext = EXT_W'({1'b1, s_q[F-1:0]}) << s_q[S_W-1:F];
        p_d = P_W'(ext >> F);
        if (z2_q) begin
            p_d = '0;
        end
`ifdef DR_ALM_SIGNED_EN
        else if (sg2_q) begin
            p_d = -p_d;
        end
`endif
    end

    // Per-stage valid bits; bubbles travel with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (advance) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    // Stage 1 register: log words, zero flag, tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            la_q   <= '0;
            lb_q   <= '0;
            z1_q   <= 1'b0;
            tag1_q <= '0;
        end else if (advance) begin
            la_q   <= la_d;
            lb_q   <= lb_d;
            z1_q   <= z1_d;
            tag1_q <= in_tag;
        end
    end

    // Stage 2 register: log sum, zero flag, tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            z2_q   <= 1'b0;
            tag2_q <= '0;
        end else if (advance) begin
            s_q    <= s_d;
            z2_q   <= z1_q;
            tag2_q <= tag1_q;
        end
    end

`ifdef DR_ALM_SIGNED_EN
    // Product sign follows its operands through stages 1 and 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sg1_q <= 1'b0;
            sg2_q <= 1'b0;
        end else if (advance) begin
            sg1_q <= sg1_d;
            sg2_q <= sg1_q;
        end
    end
`endif

    // Stage 3 register: product and tag, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            tag3_q <= '0;
        end else if (advance) begin
            p_q    <= p_d;
            tag3_q <= tag2_q;
        end
    end

endmodule

// File: tb/tb_dr_alm_pipelined_mult.sv
// Scoreboard bench for dr_alm_pipelined_mult (default parameters).
// Honours DR_ALM_SIGNED_EN in its reference model and directed cases.
module tb_dr_alm_pipelined_mult;

    localparam int unsigned A_BW  = 16;
    localparam int unsigned B_BW  = 16;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned P_W   = A_BW + B_BW;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [A_BW-1:0]  a;
    logic [B_BW-1:0]  b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [P_W-1:0]   p;
    logic [TAG_W-1:0] out_tag;

    dr_alm_pipelined_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [P_W-1:0]   p;
        int               cyc;
        bit               chk_lat;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc   = 0;
    bit               prev_stall = 0;
    logic [P_W-1:0]   prev_p;
    logic [TAG_W-1:0] prev_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: log/antilog arithmetic done with plain integers.
    function automatic logic [P_W-1:0] model(input logic [15:0] av, input logic [15:0] bv);
        longint ma, mb, la, lb, s, kk, m, r;
        int     ka, kb;
        bit     sgn;
        ma = longint'(av);
        mb = longint'(bv);
        sgn = 1'b0;
`ifdef DR_ALM_SIGNED_EN
        sgn = av[15] ^ bv[15];
        if (av[15]) ma = 65536 - ma;
        if (bv[15]) mb = 65536 - mb;
`endif
        if (ma == 0 || mb == 0) return '0;
        ka = 0;
        kb = 0;
        for (int i = 0; i < 16; i++) begin
            if ((ma >> i) != 0) ka = i;
            if ((mb >> i) != 0) kb = i;
        end
        la = longint'(ka) * 64 + 2 * (((ma - (longint'(1) << ka)) << 5) >> ka) + 1;
        lb = longint'(kb) * 64 + 2 * (((mb - (longint'(1) << kb)) << 5) >> kb) + 1;
        s  = la + lb;
        kk = s >> 6;
        m  = s & 63;
        r  = ((64 + m) << kk) >> 6;
        if (sgn) r = -r;
        return P_W'(r);
    endfunction

    // One clock: drive at negedge, then judge both handshakes before the posedge.
    task automatic step(input logic v, input logic [15:0] av, input logic [15:0] bv,
                        input logic [TAG_W-1:0] tg, input logic [P_W-1:0] ep,
                        input bit lat, input logic ordy, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        a         = av;
        b         = bv;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        cyc++;
        check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid && !out_ready && prev_stall) begin
            check("hold_p", 64'(p), 64'(prev_p));
            check("hold_tag", 64'(out_tag), 64'(prev_tag));
        end
        prev_stall = out_valid && !out_ready;
        prev_p     = p;
        prev_tag   = out_tag;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("p", 64'(p), 64'(e.p));
                check("tag", 64'(out_tag), 64'(e.tag));
                if (e.chk_lat) check("latency", 64'(cyc - e.cyc), 64'(3));
            end
        end
        acc = v && in_ready;
        if (acc) begin
            e.tag     = tg;
            e.p       = ep;
            e.cyc     = cyc;
            e.chk_lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, acc);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            idle(1);
            budget++;
        end
        check("drain_left", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        bit              acc;
        int              i;
        int              s;
        int              n_sent;
        int              budget;
        logic [15:0]     ra, rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_p", 64'(p), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed values with known products, back to back, latency tracked.
        step(1'b1, 16'd3, 16'd5,   4'd1, 32'd14, 1'b1, 1'b1, acc);
        step(1'b1, 16'd8, 16'd8,   4'd2, 32'd66, 1'b1, 1'b1, acc);
        step(1'b1, 16'd0, 16'd200, 4'd3, 32'd0,  1'b1, 1'b1, acc);
        step(1'b1, 16'd1, 16'd1,   4'd4, 32'd1,  1'b1, 1'b1, acc);
        step(1'b1, 16'd200, 16'd0, 4'd5, 32'd0,  1'b1, 1'b1, acc);
`ifdef DR_ALM_SIGNED_EN
        step(1'b1, 16'hFFFD, 16'd5,    4'd6, 32'hFFFFFFF2, 1'b1, 1'b1, acc);
        step(1'b1, 16'hFFFD, 16'hFFFB, 4'd7, 32'd14,       1'b1, 1'b1, acc);
        step(1'b1, 16'h8000, 16'd1,    4'd8, 32'hFFFF7C00, 1'b1, 1'b1, acc);
`endif
        drain();

        // Ten-pair stream with a 5-cycle consumer stall in the middle.
        i = 0;
        s = 0;
        while (i < 10 && s < 100) begin
            ra = 16'(i * 37 + 3);
            rb = 16'(i * 1001 + 11);
            step(1'b1, ra, rb, TAG_W'(i), model(ra, rb), 1'b0,
                 (s >= 5 && s < 10) ? 1'b0 : 1'b1, acc);
            if (acc) i++;
            s++;
        end
        check("stream_sent", 64'(i), 64'(10));
        drain();

        // Asynchronous reset with three products in flight.
        step(1'b1, 16'd100, 16'd7,  4'd1, model(16'd100, 16'd7),  1'b0, 1'b1, acc);
        step(1'b1, 16'd55,  16'd66, 4'd2, model(16'd55, 16'd66),  1'b0, 1'b1, acc);
        step(1'b1, 16'd9,   16'd9,  4'd3, model(16'd9, 16'd9),    1'b0, 1'b1, acc);
        @(posedge clk);
        #2;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_p", 64'(p), 64'(0));
        sb.delete();
        prev_stall = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);

        // Random sweep with random bubbles and consumer back-pressure.
        n_sent = 0;
        budget = 0;
        while (n_sent < 10000 && budget < 40000) begin
            case ($urandom_range(0, 3))
                0:       begin ra = 16'($urandom_range(0, 15)); rb = 16'($urandom); end
                1:       begin ra = 16'($urandom); rb = 16'($urandom_range(0, 3)); end
                default: begin ra = 16'($urandom); rb = 16'($urandom); end
            endcase
            step(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, ra, rb, TAG_W'(n_sent),
                 model(ra, rb), 1'b0, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, acc);
            if (acc) n_sent++;
            budget++;
        end
        check("random_sent", 64'(n_sent), 64'(10000));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
